// File: rtl/uart_pkg.sv
// Shared definitions for the Wishbone transmit-only UART.
//
// Purpose: register offsets decoded from adr[3:2], bit positions inside the
// STATUS register, and the transmit state machine encoding.
// Ports: none (package).
// Configuration: none here; see wb_uart_tx.sv for UART_TX_IRQ_EN.

package uart_pkg;

    // Word index of each register (adr[3:2]).
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // Bit positions inside STATUS.
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_LEVEL_LSB = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/wb_uart_tx_if.sv
// Wishbone classic bus bundle.
//
// Purpose: groups the Wishbone classic signals between a master and the
// peripherals on a peripheral_busses slot.
// Signals: adr (32), dat_w (32), dat_r (32), we, sel (4), cyc, stb, ack.
// Modports: master drives the request side, slave drives dat_r and ack.

interface wb_bus;

    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        we;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        ack;

    modport master (
        output adr, dat_w, we, sel, cyc, stb,
        input  dat_r, ack
    );

    modport slave (
        input  adr, dat_w, we, sel, cyc, stb,
        output dat_r, ack
    );

endinterface

// File: rtl/wb_uart_tx_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO with first-word fall-through.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset (flushes the FIFO)
//   push, din   write request and data; accepted when not full, or when a
//               pop happens in the same cycle
//   pop, dout   read request; dout always shows the oldest entry
//   full, empty, level  occupancy flags and entry count (0..DEPTH)
// Parameters: WIDTH data bits, DEPTH entries (power of two, >= 2).

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bits means full.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone classic slave, transmit-only 8N1 UART.
//
// Ports:
//   clk_in     system clock
//   reset_in   synchronous active-high reset
//   bus_slave  Wishbone classic slave (registered ack, one access per ack)
//   tx_out     serial line, idle high, driven from a flop
//   irq_out    interrupt request
// Registers (adr[3:2]): DATA (W push), STATUS, DIVISOR, CTRL.
// Configuration macro: UART_TX_IRQ_EN enables CTRL.irq_en and irq_out;
// without it irq_out is tied low and CTRL reads as zero.

module wb_uart_tx
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic  clk_in,
    input  logic  reset_in,
    wb_bus.slave  bus_slave,
    output logic  tx_out,
    output logic  irq_out
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          access;
    logic          wr_access;
    logic [1:0]    reg_sel;
    logic          data_write;
    logic [31:0]   read_data;
    logic [31:0]   ctrl_rd;
    logic [15:0]   divisor;
    logic          overflow;

    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;

    tx_state_t     state;
    logic [7:0]    shift_q;
    logic [15:0]   div_q;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_cnt;
    logic          tx_q;
    logic          busy;

    logic          unused_bus;

    // An access is taken in the cycle that raises ack, so every write has
    // exactly one effect even when stb is held.
    assign access     = bus_slave.cyc & bus_slave.stb & ~bus_slave.ack;
    assign wr_access  = access & bus_slave.we;
    assign reg_sel    = bus_slave.adr[3:2];
    assign data_write = wr_access && (reg_sel == REG_DATA);
    assign busy       = (state != IDLE);
    assign fifo_pop   = (state == IDLE) & ~fifo_empty;
    assign tx_out     = tx_q;
    assign unused_bus = ^{bus_slave.adr[31:4], bus_slave.adr[1:0],
                          bus_slave.sel, bus_slave.dat_w[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (reset_in),
        .push  (data_write),
        .pop   (fifo_pop),
        .din   (bus_slave.dat_w[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef UART_TX_IRQ_EN
    logic irq_en;
    logic irq_q;

    // Level interrupt: asserted while enabled and fully drained.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_access && (reg_sel == REG_CTRL)) irq_en <= bus_slave.dat_w[0];
            irq_q <= irq_en & fifo_empty & ~busy;
        end
    end

    assign irq_out = irq_q;
    assign ctrl_rd = {31'd0, irq_en};
`else
    assign irq_out = 1'b0;
    assign ctrl_rd = 32'd0;
`endif

    always_comb begin
        read_data = 32'd0;
        case (reg_sel)
            REG_STATUS: begin
                read_data[ST_FULL]             = fifo_full;
                read_data[ST_EMPTY]            = fifo_empty;
                read_data[ST_BUSY]             = busy;
                read_data[ST_OVERFLOW]         = overflow;
                read_data[ST_LEVEL_LSB +: 8]   = 8'(fifo_level);
            end
            REG_DIVISOR: read_data[15:0] = divisor;
            REG_CTRL:    read_data       = ctrl_rd;
            default:     read_data       = 32'd0;
        endcase
    end

    // Bus side: registered ack and read data, divisor and sticky overflow.
    // A DATA write into a full FIFO is only dropped if no pop frees a slot
    // in the same cycle.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            bus_slave.ack   <= 1'b0;
            bus_slave.dat_r <= 32'd0;
            divisor         <= DEFAULT_DIV;
            overflow        <= 1'b0;
        end else begin
            bus_slave.ack   <= access;
            bus_slave.dat_r <= (access && !bus_slave.we) ? read_data : 32'd0;
            if (wr_access && (reg_sel == REG_DIVISOR)) divisor <= bus_slave.dat_w[15:0];
            if (data_write && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end else if (wr_access && (reg_sel == REG_STATUS) && bus_slave.dat_w[ST_OVERFLOW]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Transmit FSM. tx_q is loaded with the level of the state being
    // entered, so the line changes exactly at bit boundaries. div_q is
    // captured at frame start so divisor writes only affect later frames.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state    <= IDLE;
            tx_q     <= 1'b1;
            shift_q  <= 8'd0;
            div_q    <= 16'd0;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q  <= fifo_dout;
                        div_q    <= divisor;
                        baud_cnt <= 16'd0;
                        bit_cnt  <= 3'd0;
                        tx_q     <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == div_q) begin
                        baud_cnt <= 16'd0;
                        tx_q     <= shift_q[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == div_q) begin
                        baud_cnt <= 16'd0;
                        if (bit_cnt == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt == div_q) begin
                        baud_cnt <= 16'd0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking testbench for wb_uart_tx (FIFO_DEPTH=8, DEFAULT_DIV=433).
// Honours UART_TX_IRQ_EN to pick the expected interrupt behaviour.

module tb_wb_uart_tx;

    logic clk_in = 1'b0;
    logic reset_in;
    logic tx_out;
    logic irq_out;

    int tests_run    = 0;
    int tests_failed = 0;

    wb_bus bus ();

    wb_uart_tx #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .bus_slave (bus.slave),
        .tx_out    (tx_out),
        .irq_out   (irq_out)
    );

    // 100 MHz clock.
    always #5 clk_in = ~clk_in;

    // Hard stop in case something stalls outside the bounded loops.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // One Wishbone access; returns read data and the ack latency in cycles.
    task automatic wb_access(input logic [31:0] addr, input logic write,
                             input logic [31:0] wdata,
                             output logic [31:0] rdata, output int lat);
        logic got;
        got   = 1'b0;
        rdata = 32'd0;
        lat   = 0;
        @(posedge clk_in);
        #1;
        bus.adr   = addr;
        bus.dat_w = wdata;
        bus.we    = write;
        bus.sel   = 4'hF;
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        while (!got && lat < 20) begin
            @(posedge clk_in);
            #1;
            lat++;
            if (bus.ack) begin
                got   = 1'b1;
                rdata = bus.dat_r;
            end
        end
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        if (!got) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL ack_timeout: adr=0x%08h no ack within 20 cycles", addr);
        end
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        int lat;
        wb_access(addr, 1'b1, wdata, rd, lat);
    endtask

    task automatic wb_read(input logic [31:0] addr, output logic [31:0] rdata);
        int lat;
        wb_access(addr, 1'b0, 32'd0, rdata, lat);
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        int lat;
        reset_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        tests_run++;
        if (tx_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_tx: got %b want 1", tx_out);
        end
        tests_run++;
        if (irq_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_irq: got %b want 0", irq_out);
        end
        tests_run++;
        if (bus.ack !== 1'b0 || bus.dat_r !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bus: ack=%b dat_r=0x%08h want 0/0", bus.ack, bus.dat_r);
        end
        wb_access(32'h4, 1'b0, 32'd0, rd, lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("[TB] FAIL ack_latency: got %0d want 1", lat);
        end
        tests_run++;
        if (rd !== 32'h0000_0002) begin
            tests_failed++;
            $display("[TB] FAIL reset_status: got 0x%08h want 0x00000002", rd);
        end
        wb_read(32'h8, rd);
        tests_run++;
        if (rd !== 32'd433) begin
            tests_failed++;
            $display("[TB] FAIL reset_divisor: got %0d want 433", rd);
        end
        wb_read(32'h0, rd);
        tests_run++;
        if (rd !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL data_read: got 0x%08h want 0", rd);
        end
    endtask

    task automatic test_ack_hold;
        logic [3:0] want;
        logic [3:0] seen;
        want = 4'b0101;
        @(posedge clk_in);
        #1;
        bus.adr = 32'h4;
        bus.we  = 1'b0;
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in);
            #1;
            seen[i] = bus.ack;
        end
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        tests_run++;
        if (seen !== want) begin
            tests_failed++;
            $display("[TB] FAIL ack_hold: ack pattern %b want %b", seen, want);
        end
    endtask

    task automatic test_frame;
        logic [9:0]  frame;
        logic [31:0] rd;
        frame = {1'b1, 8'hA5, 1'b0};
        wb_write(32'h8, 32'd3);
        wb_write(32'h0, 32'h0000_00A5);
        tests_run++;
        if (tx_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL frame_pre: got %b want 1", tx_out);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in);
            #1;
            tests_run++;
            if (tx_out !== frame[i/4]) begin
                tests_failed++;
                $display("[TB] FAIL frame_bit: cycle %0d got %b want %b", i, tx_out, frame[i/4]);
            end
        end
        repeat (3) @(posedge clk_in);
        #1;
        wb_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0002) begin
            tests_failed++;
            $display("[TB] FAIL frame_done_status: got 0x%08h want 0x00000002", rd);
        end
    endtask

    task automatic test_busy;
        logic [31:0] rd;
        wb_write(32'h0, 32'h0000_0000);
        wb_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0006) begin
            tests_failed++;
            $display("[TB] FAIL busy_status: got 0x%08h want 0x00000006", rd);
        end
        repeat (45) @(posedge clk_in);
        wb_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0002) begin
            tests_failed++;
            $display("[TB] FAIL busy_clear: got 0x%08h want 0x00000002", rd);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] rd;
        for (int i = 0; i < 10; i++) wb_write(32'h0, 32'h10 + i);
        wb_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_080D) begin
            tests_failed++;
            $display("[TB] FAIL overflow_status: got 0x%08h want 0x0000080D", rd);
        end
        wb_write(32'h4, 32'h8);
        wb_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0805) begin
            tests_failed++;
            $display("[TB] FAIL overflow_clear: got 0x%08h want 0x00000805", rd);
        end
        repeat (500) @(posedge clk_in);
        wb_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0002) begin
            tests_failed++;
            $display("[TB] FAIL overflow_drain: got 0x%08h want 0x00000002", rd);
        end
    endtask

    task automatic test_divisor_change;
        logic        samples [150];
        logic [31:0] rd;
        int runs;
        int cur;
        int len [2];
        runs   = 0;
        cur    = 0;
        len[0] = 0;
        len[1] = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    @(posedge clk_in);
                    #1;
                    samples[i] = tx_out;
                end
            end
            begin
                wb_write(32'h0, 32'h0000_00FF);
                wb_write(32'h0, 32'h0000_00FF);
                wb_write(32'h8, 32'd7);
            end
        join
        // With 0xFF bytes only the start bit is low, so each low run is one
        // bit period.
        for (int i = 0; i < 150; i++) begin
            if (samples[i] == 1'b0) begin
                cur++;
            end else if (cur > 0) begin
                if (runs < 2) len[runs] = cur;
                runs++;
                cur = 0;
            end
        end
        tests_run++;
        if (runs !== 2) begin
            tests_failed++;
            $display("[TB] FAIL div_runs: got %0d start bits want 2", runs);
        end
        tests_run++;
        if (len[0] !== 4) begin
            tests_failed++;
            $display("[TB] FAIL div_old_frame: bit length %0d want 4", len[0]);
        end
        tests_run++;
        if (len[1] !== 8) begin
            tests_failed++;
            $display("[TB] FAIL div_new_frame: bit length %0d want 8", len[1]);
        end
        wb_read(32'h8, rd);
        tests_run++;
        if (rd !== 32'd7) begin
            tests_failed++;
            $display("[TB] FAIL div_readback: got %0d want 7", rd);
        end
        wb_write(32'h8, 32'd3);
    endtask

    task automatic test_reset_midframe;
        logic [31:0] rd;
        logic        quiet;
        wb_write(32'h0, 32'h0000_00A5);
        wb_write(32'h0, 32'h0000_005A);
        // Land inside data bit 3 of 0xA5, which is a 0.
        repeat (16) @(posedge clk_in);
        #1;
        tests_run++;
        if (tx_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midframe_bit3: got %b want 0", tx_out);
        end
        reset_in = 1'b1;
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        tests_run++;
        if (tx_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midframe_reset_tx: got %b want 1", tx_out);
        end
        wb_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0002) begin
            tests_failed++;
            $display("[TB] FAIL midframe_status: got 0x%08h want 0x00000002", rd);
        end
        quiet = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk_in);
            #1;
            if (tx_out !== 1'b1) quiet = 1'b0;
        end
        tests_run++;
        if (quiet !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midframe_quiet: line left idle got %b want 1", quiet);
        end
        wb_read(32'h8, rd);
        tests_run++;
        if (rd !== 32'd433) begin
            tests_failed++;
            $display("[TB] FAIL midframe_divisor: got %0d want 433", rd);
        end
        wb_write(32'h8, 32'd3);
    endtask

    task automatic test_irq;
        logic [31:0] rd;
        logic        want_on;
`ifdef UART_TX_IRQ_EN
        want_on = 1'b1;
`else
        want_on = 1'b0;
`endif
        wb_write(32'hC, 32'h1);
        repeat (2) @(posedge clk_in);
        #1;
        tests_run++;
        if (irq_out !== want_on) begin
            tests_failed++;
            $display("[TB] FAIL irq_enable: got %b want %b", irq_out, want_on);
        end
        wb_read(32'hC, rd);
        tests_run++;
        if (rd !== {31'd0, want_on}) begin
            tests_failed++;
            $display("[TB] FAIL ctrl_read: got 0x%08h want %0d", rd, want_on);
        end
        wb_write(32'h0, 32'h0000_0055);
        repeat (3) @(posedge clk_in);
        #1;
        tests_run++;
        if (irq_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL irq_drop: got %b want 0", irq_out);
        end
        repeat (20) @(posedge clk_in);
        #1;
        tests_run++;
        if (irq_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL irq_midframe: got %b want 0", irq_out);
        end
        repeat (40) @(posedge clk_in);
        #1;
        tests_run++;
        if (irq_out !== want_on) begin
            tests_failed++;
            $display("[TB] FAIL irq_return: got %b want %b", irq_out, want_on);
        end
    endtask

    // Run each scenario in order, then report.
    initial begin
        reset_in  = 1'b1;
        bus.adr   = 32'd0;
        bus.dat_w = 32'd0;
        bus.we    = 1'b0;
        bus.sel   = 4'h0;
        bus.cyc   = 1'b0;
        bus.stb   = 1'b0;
        test_reset();
        test_ack_hold();
        test_frame();
        test_busy();
        test_overflow();
        test_divisor_change();
        test_reset_midframe();
        test_irq();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
